as1802_bus_responder: RTL and testbench
=======================================

Name: as1802_bus_responder

Overview:
- Memory-mapped responder on the far end of the AS1802 CPU bus.
- Consumes the CPU's multiplexed 8-bit address, TPA, MRD, MWR, SC and Q, and supplies read data, EF flags and the interrupt request.
- Contains a small on-chip RAM window plus a register block holding a prescaled countdown timer that raises intr.
- Sits beside the CPU wrapper in the top-level SoC.

Parameters:
- RAM_BASE, 16'h8000, base address of the RAM window (aligned to 2^RAM_AW).
- RAM_AW, 6, RAM address width; 64 bytes by default.
- REG_BASE, 16'hFF00, base of the 8-byte register block (aligned to 8).
- PRESCALE, 16, clocks per timer decrement; must be ≥1.

Ports:
- clk  in  1  system clock, shared with the CPU.
- rst  in  1  asynchronous, active-low reset.
- bus_addr  in  8  CPU address pins: high byte while tpa=1, low byte otherwise.
- bus_wdata  in  8  CPU data_out.
- bus_rdata  out  8  data returned to the CPU data_in.
- bus_oe  out  1  high while this block drives bus_rdata.
- tpa  in  1  address-high strobe.
- mrd  in  1  memory read, active-low.
- mwr  in  1  memory write, active-low.
- sc  in  2  state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt.
- q  in  1  CPU Q flag.
- intr  out  1  interrupt request to the CPU, active-high.
- ef  out  4  EF flag inputs to the CPU.

Behaviour:
- Reset values:
  - bus_rdata=0, bus_oe=0, intr=0, ef=0.
  - All registers 0, address latch 0.
  - FSM in IDLE.
  - RAM contents undefined.
- Address demux:
  - When tpa=1, addr_hi <= bus_addr; the latch holds until the next tpa.
  - Effective address = {addr_hi, bus_addr}.
- FSM states and transitions:
  - IDLE -> ACCESS when mrd=0 or mwr=0 and the address hits RAM or a register.
  - ACCESS -> DONE on the cycle after a write commits, or immediately for reads.
  - DONE -> IDLE when mrd=1 and mwr=1.
  - tpa=1 in any state forces IDLE; a new cycle has begun.
- Reads:
  - bus_rdata and bus_oe are registered, with 1-cycle latency from mrd=0 plus a hit.
  - bus_rdata updates every cycle while mrd=0, tracking the address.
  - bus_oe drops the cycle after mrd returns high or the address misses.
  - On a miss, bus_oe=0 and bus_rdata=0.
- Writes:
  - Committed exactly once per cycle, on the first clock with mwr=0 and a hit (IDLE->ACCESS).
  - A held mwr does not re-commit, which protects write-1-to-clear bits.
  - If mrd and mwr are both low, write wins and bus_oe=0.
- Register map (offset from REG_BASE):
  - 0 CTRL, rw: bit0 timer_en, bit1 irq_en, bit2 auto_reload.
  - 1 STATUS:
    - bit0 expired, W1C.
    - bit1 q_mirror, ro; the current sampled q.
    - bit2 dma_seen, W1C; set when sc=10 is sampled with mrd=0 or mwr=0.
  - 2 RELOAD, rw. Writing it while timer_en=0 also loads COUNT.
  - 3 COUNT, ro; current count.
  - 4 EFOUT, rw, bits[3:0] drive ef directly.
  - 5–7 reserved: read 0, writes ignored.
- Timer:
  - A prescaler counts 0..PRESCALE-1 while timer_en=1 and is cleared when timer_en=0.
  - On prescaler wrap with COUNT>0, COUNT decrements.
  - On the 1->0 transition, expired is set. COUNT then reloads from RELOAD if auto_reload=1; otherwise timer_en is cleared.
  - With COUNT=0 and timer_en=1, the timer stays at 0 and raises no further expiry.
- intr = expired & irq_en, registered.
  - Cleared only by a W1C write to STATUS.
  - If expiry and W1C coincide in the same cycle, set wins.
- Reset mid-cycle: all state returns to reset values immediately, so bus_oe drops asynchronously.

Decomposition:
- Package as1802_resp_pkg holds:
  - Register offsets: REG_CTRL=0, REG_STATUS=1, REG_RELOAD=2, REG_COUNT=3, REG_EFOUT=4.
  - CTRL/STATUS bit indices.
  - SC encodings: SC_FETCH, SC_EXEC, SC_DMA, SC_INT.
  - FSM state enum: IDLE, ACCESS, DONE.
- Sub-module as1802_resp_timer contains the prescaler, COUNT, RELOAD load, the expiry pulse and the auto-reload/disable logic.
  - Inputs: en, auto_reload, load strobe, load value.
  - Outputs: count, expire_pulse, clear_en.

Test Plan:
- RAM write/read: tpa with 0x80, then 0x05 with mwr low for 3 cycles carrying 0xA5. Then read 0x8005 → bus_oe=1 and bus_rdata=0xA5 one cycle after mrd falls; exactly one write commit.
- Miss: read 0x4005 → bus_oe stays 0 and bus_rdata=0.
- Timer, one-shot (PRESCALE=16): write RELOAD=3, then CTRL=0x03. expired and intr rise 48±1 clocks after the CTRL write; timer_en reads back 0 and COUNT=0.
- Auto-reload plus W1C race: CTRL=0x07, RELOAD=2; issue the W1C to STATUS on the exact expiry cycle → expired stays 1. A later W1C → intr=0, and COUNT has reloaded to 2.
- EF, Q and DMA: write EFOUT=0x9 → ef=4'b1001. Drive q=1 → STATUS bit1=1. Run a DMA cycle with sc=10 → dma_seen=1.
- Async reset: assert rst low during an active read → bus_oe=0 and intr=0 in the same cycle; after release, registers read 0.

Source files
------------

// File: rtl/as1802_resp_pkg.sv
// Shared definitions for the AS1802 bus responder: register map offsets,
// control/status bit positions, CPU state-code encodings and FSM states.
package as1802_resp_pkg;

    // Register offsets inside the 8-byte register block.
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_RELOAD = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_EFOUT  = 3'd4;

    // CTRL bit positions.
    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_AUTO_RLD = 2;

    // STATUS bit positions.
    localparam int STAT_EXPIRED  = 0;
    localparam int STAT_Q_MIRROR = 1;
    localparam int STAT_DMA_SEEN = 2;

    // CPU state codes presented on sc.
    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    // Bus-cycle tracking FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } resp_state_e;

    // Write-1-to-clear update with set priority: a set in the same cycle wins.
    function automatic logic w1c_update(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/as1802_resp_timer.sv
// Prescaled 8-bit countdown timer. The prescaler runs only while enabled;
// each prescaler wrap decrements a non-zero count. The 1->0 step pulses
// expire_o and either reloads (auto-reload) or asks the owner to drop enable.
module as1802_resp_timer #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       auto_reload_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] reload_val_i,
    output logic [7:0] count_o,
    output logic       expire_o,
    output logic       clear_en_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [7:0]    count_q, count_d;
    logic          wrap;

    // Prescaler: free-runs 0..PRESCALE-1 while enabled, held at 0 otherwise.
    always_comb begin
        psc_d = psc_q;
        wrap  = 1'b0;
        if (!en_i) begin
            psc_d = {PW{1'b0}};
        end else if (psc_q == PSC_MAX) begin
            psc_d = {PW{1'b0}};
            wrap  = 1'b1;
        end else begin
            psc_d = psc_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Count update: explicit load beats ticking; a zero count stays parked.
    always_comb begin
        count_d    = count_q;
        expire_o   = 1'b0;
        clear_en_o = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (wrap && (count_q != 8'd0)) begin
            if (count_q == 8'd1) begin
                expire_o   = 1'b1;
                count_d    = auto_reload_i ? reload_val_i : 8'd0;
                clear_en_o = ~auto_reload_i;
            end else begin
                count_d = count_q - 8'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q   <= {PW{1'b0}};
            count_q <= 8'd0;
        end else begin
            psc_q   <= psc_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/as1802_bus_responder.sv
// Memory-mapped responder on the AS1802 CPU bus: demultiplexes the address,
// serves a small RAM window and a register block with a countdown timer,
// and drives read data, EF flags and the interrupt request.
module as1802_bus_responder
    import as1802_resp_pkg::*;
#(
    parameter logic [15:0] RAM_BASE = 16'h8000,
    parameter int          RAM_AW   = 6,
    parameter logic [15:0] REG_BASE = 16'hFF00,
    parameter int          PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus_addr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       bus_oe,
    input  logic       tpa,
    input  logic       mrd,
    input  logic       mwr,
    input  logic [1:0] sc,
    input  logic       q,
    output logic       intr,
    output logic [3:0] ef
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    // Registered state.
    resp_state_e state_q, state_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        expired_q, expired_d;
    logic        dma_seen_q, dma_seen_d;
    logic        q_mirror_q, q_mirror_d;
    logic [7:0]  reload_q, reload_d;
    logic [3:0]  efout_q, efout_d;
    logic        intr_q, intr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        oe_q, oe_d;

    logic [7:0]  ram_q [RAM_DEPTH];

    // Address decode and strobes.
    logic [15:0]       eff_addr;
    logic              ram_hit, reg_hit, hit;
    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        reg_off;
    logic              wr_commit, rd_active;
    logic              reg_wr, ram_we, ctrl_wr, status_wr, reload_wr, efout_wr;
    logic              dma_set;
    logic [7:0]        rd_mux, status_val, ram_rd;

    // Timer interface.
    logic [7:0] tmr_count;
    logic       tmr_expire, tmr_clear_en, tmr_load;

    assign eff_addr = {addr_hi_q, bus_addr};
    assign ram_hit  = (eff_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign reg_hit  = (eff_addr[15:3] == REG_BASE[15:3]);
    assign hit      = ram_hit | reg_hit;
    assign ram_idx  = eff_addr[RAM_AW-1:0];
    assign reg_off  = eff_addr[2:0];
    assign ram_rd   = ram_q[ram_idx];

    // Reads track the address every cycle; a simultaneous write suppresses them.
    assign rd_active = ~tpa & ~mrd & mwr & hit;

    assign reg_wr    = wr_commit & reg_hit & ~ram_hit;
    assign ram_we    = wr_commit & ram_hit;
    assign ctrl_wr   = reg_wr & (reg_off == REG_CTRL);
    assign status_wr = reg_wr & (reg_off == REG_STATUS);
    assign reload_wr = reg_wr & (reg_off == REG_RELOAD);
    assign efout_wr  = reg_wr & (reg_off == REG_EFOUT);
    assign tmr_load  = reload_wr & ~ctrl_q[CTRL_TIMER_EN];

    // Any bus request in a DMA state code marks DMA activity, hit or not.
    assign dma_set   = (sc == SC_DMA) & (~mrd | ~mwr);

    as1802_resp_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .en_i          (ctrl_q[CTRL_TIMER_EN]),
        .auto_reload_i (ctrl_q[CTRL_AUTO_RLD]),
        .load_i        (tmr_load),
        .load_val_i    (bus_wdata),
        .reload_val_i  (reload_q),
        .count_o       (tmr_count),
        .expire_o      (tmr_expire),
        .clear_en_o    (tmr_clear_en)
    );

    // FSM next state; the single write commit happens on the IDLE->ACCESS step.
    always_comb begin
        state_d   = state_q;
        wr_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (tpa) begin
                    state_d = IDLE;
                end else if ((~mrd | ~mwr) & hit) begin
                    state_d   = ACCESS;
                    wr_commit = ~mwr;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (tpa) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (tpa || (mrd && mwr)) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Assemble STATUS from its individual bits.
    always_comb begin
        status_val                = 8'h00;
        status_val[STAT_EXPIRED]  = expired_q;
        status_val[STAT_Q_MIRROR] = q_mirror_q;
        status_val[STAT_DMA_SEEN] = dma_seen_q;
    end

    // Read data selection: RAM first, then the register map, else zero.
    always_comb begin
        rd_mux = 8'h00;
        if (ram_hit) begin
            rd_mux = ram_rd;
        end else if (reg_hit) begin
            case (reg_off)
                REG_CTRL:   rd_mux = {5'b00000, ctrl_q};
                REG_STATUS: rd_mux = status_val;
                REG_RELOAD: rd_mux = reload_q;
                REG_COUNT:  rd_mux = tmr_count;
                REG_EFOUT:  rd_mux = {4'b0000, efout_q};
                default:    rd_mux = 8'h00;
            endcase
        end else begin
            rd_mux = 8'h00;
        end
    end

    // Next-state for the address latch, register block, interrupt and read port.
    always_comb begin
        addr_hi_d  = tpa ? bus_addr : addr_hi_q;
        q_mirror_d = q;

        ctrl_d = ctrl_wr ? bus_wdata[2:0] : ctrl_q;
        if (tmr_clear_en) begin
            ctrl_d[CTRL_TIMER_EN] = 1'b0;
        end else begin
            ctrl_d[CTRL_TIMER_EN] = ctrl_d[CTRL_TIMER_EN];
        end

        expired_d  = w1c_update(expired_q, tmr_expire,
                                status_wr & bus_wdata[STAT_EXPIRED]);
        dma_seen_d = w1c_update(dma_seen_q, dma_set,
                                status_wr & bus_wdata[STAT_DMA_SEEN]);
        reload_d   = reload_wr ? bus_wdata : reload_q;
        efout_d    = efout_wr ? bus_wdata[3:0] : efout_q;
        intr_d     = expired_d & ctrl_d[CTRL_IRQ_EN];

        oe_d    = rd_active;
        rdata_d = rd_active ? rd_mux : 8'h00;
    end

    // Register bank for everything except the RAM array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_hi_q  <= 8'h00;
            ctrl_q     <= 3'b000;
            expired_q  <= 1'b0;
            dma_seen_q <= 1'b0;
            q_mirror_q <= 1'b0;
            reload_q   <= 8'h00;
            efout_q    <= 4'h0;
            intr_q     <= 1'b0;
            rdata_q    <= 8'h00;
            oe_q       <= 1'b0;
        end else begin
            addr_hi_q  <= addr_hi_d;
            ctrl_q     <= ctrl_d;
            expired_q  <= expired_d;
            dma_seen_q <= dma_seen_d;
            q_mirror_q <= q_mirror_d;
            reload_q   <= reload_d;
            efout_q    <= efout_d;
            intr_q     <= intr_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
        end
    end

    // RAM window storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus_wdata;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_oe    = oe_q;
    assign intr      = intr_q;
    assign ef        = efout_q;

endmodule

// File: tb/tb_as1802_bus_responder.sv
// Randomized self-checking bench for the AS1802 bus responder.
module tb_as1802_bus_responder;

    localparam int          PRESCALE = 16;
    localparam logic [15:0] RAM_BASE = 16'h8000;
    localparam logic [15:0] REG_BASE = 16'hFF00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_addr, bus_wdata, bus_rdata;
    logic       bus_oe, tpa, mrd, mwr, q, intr;
    logic [1:0] sc;
    logic [3:0] ef;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_commit = 0;

    // Reference model state.
    logic [7:0] ram_m [64];
    int         written_q [$];

    as1802_bus_responder #(
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (6),
        .REG_BASE (REG_BASE),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_oe    (bus_oe),
        .tpa       (tpa),
        .mrd       (mrd),
        .mwr       (mwr),
        .sc        (sc),
        .q         (q),
        .intr      (intr),
        .ef        (ef)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bus write: address phase, then mwr low for 'hold' cycles. Data changes
    // to 'late' after the first cycle so a re-commit would be visible.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] late, input int hold);
        tpa = 1'b1; bus_addr = a[15:8]; mrd = 1'b1; mwr = 1'b1;
        @(negedge clk);
        tpa = 1'b0; bus_addr = a[7:0]; bus_wdata = d; mwr = 1'b0;
        last_commit = cyc + 1;
        @(negedge clk);
        bus_wdata = late;
        for (int i = 1; i < hold; i++) @(negedge clk);
        mwr = 1'b1;
        @(negedge clk);
    endtask

    // Bus read: sample data one clock after mrd falls.
    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic o);
        tpa = 1'b1; bus_addr = a[15:8]; mrd = 1'b1; mwr = 1'b1;
        @(negedge clk);
        tpa = 1'b0; bus_addr = a[7:0]; mrd = 1'b0;
        @(negedge clk);
        d = bus_rdata; o = bus_oe;
        mrd = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d; logic o;
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus_oe); end
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus_rdata); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b want 0", intr); end
        checks++; if (ef !== 4'h0) begin errors++; $display("FAIL reset_ef: got %h want 0", ef); end
        for (int r = 0; r < 8; r++) begin
            bus_read(REG_BASE + 16'(r), d, o);
            checks++;
            if (d !== 8'h00 || o !== 1'b1) begin
                errors++; $display("FAIL reset_reg%0d: got %h oe=%b want 00 oe=1", r, d, o);
            end
        end
    endtask

    task automatic test_ram_write_read();
        logic [7:0] d; logic o;
        bus_write(16'h8005, 8'hA5, 8'h5A, 3);
        ram_m[5] = 8'hA5; written_q.push_back(5);
        bus_read(16'h8005, d, o);
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ram_oe: got %b want 1", o); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL ram_single_commit: got %h want a5", d); end
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL ram_oe_drop: got %b want 0", bus_oe); end
    endtask

    task automatic test_miss();
        logic [7:0] d; logic o;
        logic [15:0] miss_a [3];
        miss_a[0] = 16'h4005; miss_a[1] = 16'h8040; miss_a[2] = 16'hFEFF;
        for (int i = 0; i < 3; i++) begin
            bus_read(miss_a[i], d, o);
            checks++;
            if (o !== 1'b0 || d !== 8'h00) begin
                errors++; $display("FAIL miss_%h: got %h oe=%b want 00 oe=0", miss_a[i], d, o);
            end
        end
        bus_write(16'hFF06, 8'hFF, 8'hFF, 1);
        bus_read(16'hFF06, d, o);
        checks++;
        if (o !== 1'b1 || d !== 8'h00) begin
            errors++; $display("FAIL reserved_reg: got %h oe=%b want 00 oe=1", d, o);
        end
    endtask

    task automatic test_random_ram();
        logic [7:0] d, v; logic o;
        int idx, op;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0 || written_q.size() == 0) begin
                idx = $urandom_range(0, 63);
                v = 8'($urandom);
                bus_write(RAM_BASE + 16'(idx), v, ~v, $urandom_range(1, 3));
                ram_m[idx] = v; written_q.push_back(idx);
            end else if (op == 1) begin
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                bus_read(RAM_BASE + 16'(idx), d, o);
                checks++;
                if (o !== 1'b1 || d !== ram_m[idx]) begin
                    errors++; $display("FAIL rand_ram[%0d]: got %h oe=%b want %h oe=1", idx, d, o, ram_m[idx]);
                end
            end else begin
                bus_read({8'($urandom_range(0, 127)), 8'($urandom)}, d, o);
                checks++;
                if (o !== 1'b0 || d !== 8'h00) begin
                    errors++; $display("FAIL rand_miss: got %h oe=%b want 00 oe=0", d, o);
                end
            end
        end
    endtask

    task automatic test_write_wins();
        logic [7:0] d; logic o;
        tpa = 1'b1; bus_addr = 8'h80; mrd = 1'b1; mwr = 1'b1;
        @(negedge clk);
        tpa = 1'b0; bus_addr = 8'h10; bus_wdata = 8'h3C; mrd = 1'b0; mwr = 1'b0;
        @(negedge clk);
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL write_wins_oe: got %b want 0", bus_oe); end
        mrd = 1'b1; mwr = 1'b1;
        @(negedge clk);
        ram_m[16] = 8'h3C; written_q.push_back(16);
        bus_read(16'h8010, d, o);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL write_wins_data: got %h want 3c", d); end
    endtask

    task automatic test_timer_oneshot();
        logic [7:0] d; logic o;
        int c_edge, delta;
        int want;
        want = 3 * PRESCALE;
        bus_write(REG_BASE + 16'd2, 8'd3, 8'd3, 1);
        bus_write(REG_BASE + 16'd0, 8'h03, 8'h03, 1);
        c_edge = last_commit;
        for (int i = 0; i < 4 * want && intr !== 1'b1; i++) @(negedge clk);
        delta = cyc - c_edge;
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL oneshot_timeout: intr=%b after %0d clocks", intr, delta);
        end else if (delta < want - 1 || delta > want + 1) begin
            errors++; $display("FAIL oneshot_delay: got %0d clocks want %0d", delta, want);
        end
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL oneshot_status: got %h want 01", d); end
        bus_read(REG_BASE + 16'd0, d, o);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL oneshot_ctrl: got %h want 02", d); end
        bus_read(REG_BASE + 16'd3, d, o);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_count: got %h want 00", d); end
    endtask

    task automatic test_auto_reload_race();
        logic [7:0] d; logic o;
        int target;
        bus_write(REG_BASE + 16'd1, 8'h01, 8'h01, 1);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL w1c_pre: intr got %b want 0", intr); end
        bus_write(REG_BASE + 16'd2, 8'd2, 8'd2, 1);
        bus_write(REG_BASE + 16'd0, 8'h07, 8'h07, 1);
        target = last_commit + 2 * PRESCALE;
        while (cyc < target - 2) @(negedge clk);
        bus_write(REG_BASE + 16'd1, 8'h01, 8'h01, 1);
        checks++; if (last_commit != target) begin errors++; $display("FAIL race_align: commit %0d want %0d", last_commit, target); end
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL race_intr: got %b want 1", intr); end
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h01) begin errors++; $display("FAIL race_status: got %h want 01", d); end
        bus_write(REG_BASE + 16'd1, 8'h01, 8'h01, 1);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL w1c_clear_intr: got %b want 0", intr); end
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL w1c_status: got %h want 00", d); end
        bus_read(REG_BASE + 16'd3, d, o);
        checks++; if (d !== 8'd2) begin errors++; $display("FAIL auto_reload_count: got %h want 02", d); end
        bus_write(REG_BASE + 16'd0, 8'h00, 8'h00, 1);
    endtask

    task automatic test_ef_q_dma();
        logic [7:0] d, v; logic o;
        for (int n = 0; n < 6; n++) begin
            v = 8'($urandom);
            bus_write(REG_BASE + 16'd4, v, ~v, 2);
            checks++; if (ef !== v[3:0]) begin errors++; $display("FAIL rand_ef: got %h want %h", ef, v[3:0]); end
            v = 8'($urandom);
            bus_write(REG_BASE + 16'd2, v, ~v, 1);
            bus_read(REG_BASE + 16'd3, d, o);
            checks++; if (d !== v) begin errors++; $display("FAIL reload_loads_count: got %h want %h", d, v); end
        end
        bus_write(REG_BASE + 16'd4, 8'h09, 8'h09, 1);
        checks++; if (ef !== 4'b1001) begin errors++; $display("FAIL efout: got %b want 1001", ef); end
        q = 1'b1;
        @(negedge clk); @(negedge clk);
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL q_mirror: got %h want 02", d); end
        sc = 2'b10;
        bus_read(16'h8005, d, o);
        sc = 2'b01;
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL dma_seen: got %h want 06", d); end
        bus_write(REG_BASE + 16'd1, 8'h04, 8'h04, 1);
        bus_read(REG_BASE + 16'd1, d, o);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL dma_w1c: got %h want 02", d); end
        q = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [7:0] d; logic o;
        bus_write(REG_BASE + 16'd2, 8'd1, 8'd1, 1);
        bus_write(REG_BASE + 16'd0, 8'h03, 8'h03, 1);
        for (int i = 0; i < 4 * PRESCALE && intr !== 1'b1; i++) @(negedge clk);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL prereset_intr: got %b want 1", intr); end
        tpa = 1'b1; bus_addr = 8'h80; mrd = 1'b1; mwr = 1'b1;
        @(negedge clk);
        tpa = 1'b0; bus_addr = 8'h05; mrd = 1'b0;
        @(negedge clk);
        checks++; if (bus_oe !== 1'b1) begin errors++; $display("FAIL prereset_oe: got %b want 1", bus_oe); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus_oe !== 1'b0 || intr !== 1'b0 || ef !== 4'h0) begin
            errors++; $display("FAIL async_reset: oe=%b intr=%b ef=%h want 0 0 0", bus_oe, intr, ef);
        end
        mrd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            bus_read(REG_BASE + 16'(r), d, o);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL post_reset_reg%0d: got %h want 00", r, d); end
        end
    endtask

    initial begin
        rst = 1'b0; tpa = 1'b0; mrd = 1'b1; mwr = 1'b1;
        bus_addr = 8'h00; bus_wdata = 8'h00; sc = 2'b01; q = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_ram_write_read();
        test_miss();
        test_random_ram();
        test_write_wins();
        test_timer_oneshot();
        test_auto_reload_race();
        test_ef_q_dma();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
